// File: rtl/memory_dump_streamer.sv
// Streams a contiguous range of a registered-read memory port out over valid/ready.
module memory_dump_streamer #(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned ADDRESS_WIDTH = 11
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   input  logic [ADDRESS_WIDTH:0]   length,
   input  logic                     abort,
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic                     mem_re,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic                     out_valid,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_last,
   input  logic                     out_ready
);

   localparam int unsigned LEN_W = ADDRESS_WIDTH + 1;

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic                     done_q, done_d;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q;
   logic [LEN_W-1:0]         to_issue_q;
   logic [LEN_W-1:0]         to_send_q;
   logic                     inflight_q;
   logic [DATA_WIDTH-1:0]    fifo0_q, fifo1_q;
   logic                     rd_ptr_q, wr_ptr_q;
   logic [1:0]               count_q;

   logic                     deq;
   logic                     issue;
   logic                     final_xfer;
   logic                     launch;
   logic [2:0]               occupancy;

   // Stream handshake, read-issue credit check and run launch
   always_comb begin
      deq        = (count_q != 2'd0) && out_ready;
      occupancy  = 3'(count_q) + 3'(inflight_q) - 3'(deq);
      issue      = (state_q == RUN) && (to_issue_q != '0) && (occupancy < 3'd2);
      final_xfer = deq && (to_send_q == LEN_W'(1));
      launch     = (state_q == IDLE) && start && (length != '0);
   end

   // Output mapping; mem_addr holds the last issued address between reads
   always_comb begin
      busy      = (state_q == RUN);
      done      = done_q;
      mem_re    = issue;
      mem_addr  = issue ? addr_q : mem_addr_q;
      out_valid = (count_q != 2'd0);
      out_data  = rd_ptr_q ? fifo1_q : fifo0_q;
      out_last  = out_valid && (to_send_q == LEN_W'(1));
   end

   // Next-state and done-pulse logic; abort beats a simultaneous final transfer
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (length != '0) state_d = RUN;
               else              done_d  = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (final_xfer) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // Address/count bookkeeping and the 2-entry skid FIFO fed by the read port
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         addr_q     <= '0;
         mem_addr_q <= '0;
         to_issue_q <= '0;
         to_send_q  <= '0;
         inflight_q <= 1'b0;
         fifo0_q    <= '0;
         fifo1_q    <= '0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         if (launch) begin
            addr_q     <= base_addr;
            to_issue_q <= length;
            to_send_q  <= length;
         end
         if (issue) begin
            addr_q     <= addr_q + ADDRESS_WIDTH'(1);
            mem_addr_q <= addr_q;
            to_issue_q <= to_issue_q - LEN_W'(1);
         end
         if (deq) begin
            to_send_q <= to_send_q - LEN_W'(1);
            rd_ptr_q  <= ~rd_ptr_q;
         end
         if (inflight_q) begin
            if (wr_ptr_q) fifo1_q <= mem_rdata;
            else          fifo0_q <= mem_rdata;
            wr_ptr_q <= ~wr_ptr_q;
         end
         inflight_q <= issue;
         count_q    <= count_q + 2'(inflight_q) - 2'(deq);
         // Abort drops buffered and in-flight words
         if ((state_q == RUN) && abort) begin
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_memory_dump_streamer.sv
// Directed bench for memory_dump_streamer with a behavioural registered-read memory.
module tb_memory_dump_streamer;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 11;
   localparam int unsigned DEPTH = 2048;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          abort;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_addr;
   logic          mem_re;
   logic [DW-1:0] mem_rdata;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready;

   logic [DW-1:0] mem_model [DEPTH];

   int checks = 0;
   int errors = 0;

   // Results of the last run
   int q_data[$];
   int q_last[$];
   int q_addr[$];
   int done_cycle, abort_cycle, first_xfer_cycle, last_xfer_cycle;
   int viol, busy_cnt, valid_cnt, last_cnt, done_cnt;
   logic timed_out, busy_at_done, valid_after_abort, busy_after_abort;

   memory_dump_streamer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   always #5 clock = ~clock;

   // Registered-read memory: data valid one cycle after issue
   always @(posedge clock) begin
      if (mem_re) mem_rdata <= mem_model[mem_addr];
   end

   // Drive one run from a start pulse and record everything observed
   task automatic run(input int base, input int len, input int ready_pct, input int abort_after,
                      input int stall_until, input int restart_at, input int max_cycles);
      int cyc, xfers, outstanding;
      logic prev_stall;
      logic [DW-1:0] prev_data;
      q_data.delete(); q_last.delete(); q_addr.delete();
      done_cycle = -1; abort_cycle = -1; first_xfer_cycle = -1; last_xfer_cycle = -1;
      viol = 0; busy_cnt = 0; valid_cnt = 0; last_cnt = 0; done_cnt = 0;
      timed_out = 1'b0; busy_at_done = 1'b0; valid_after_abort = 1'b0; busy_after_abort = 1'b0;
      @(posedge clock); #1;
      start = 1'b1; base_addr = AW'(base); length = (AW+1)'(len); abort = 1'b0; out_ready = 1'b0;
      cyc = 0; xfers = 0; outstanding = 0; prev_stall = 1'b0; prev_data = '0;
      while (1) begin
         @(posedge clock); #1;
         cyc++;
         start = (cyc == restart_at);
         if (start) begin base_addr = AW'(500); length = (AW+1)'(7); end
         out_ready = (cyc > stall_until) && ($urandom_range(0, 99) < ready_pct);
         abort = (abort_after >= 0) && (abort_cycle < 0) && (xfers == abort_after);
         if (abort) abort_cycle = cyc;
         @(negedge clock);
         if (abort_cycle >= 0 && cyc == abort_cycle + 1) begin
            valid_after_abort = out_valid; busy_after_abort = busy; outstanding = 0;
         end
         if (busy) busy_cnt++;
         if (out_valid) valid_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cycle < 0) begin done_cycle = cyc; busy_at_done = busy; end
         end
         if (prev_stall && !(abort_cycle >= 0 && cyc == abort_cycle + 1))
            if (!out_valid || out_data !== prev_data) viol++;
         if (mem_re) begin q_addr.push_back(int'(mem_addr)); outstanding++; end
         if (out_valid && out_ready) begin
            q_data.push_back(int'(out_data));
            q_last.push_back(int'(out_last));
            if (out_last) last_cnt++;
            if (first_xfer_cycle < 0) first_xfer_cycle = cyc;
            last_xfer_cycle = cyc;
            xfers++; outstanding--;
         end
         if (outstanding > 2) viol++;
         prev_stall = out_valid && !out_ready;
         prev_data = out_data;
         if (done_cycle >= 0 && abort_after < 0) break;
         if (abort_cycle >= 0 && cyc >= abort_cycle + 6) break;
         if (cyc >= max_cycles) begin timed_out = 1'b1; break; end
      end
      @(posedge clock); #1;
      start = 1'b0; abort = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
      checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL reset_mem_re: got %0b expected 0", mem_re); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b expected 0", out_last); end
      checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %0d expected 0", out_data); end
   endtask

   task automatic test_basic(input int base);
      run(base, 4, 100, -1, 0, -1, 50);
      checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got timeout expected done"); end
      checks++; if (q_data.size() != 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 4; i++) begin
         checks++; if (q_data[i] != base + i) begin errors++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, q_data[i], base + i); end
         checks++; if (q_last[i] != (i == 3 ? 1 : 0)) begin errors++; $display("FAIL basic_last[%0d]: got %0d expected %0d", i, q_last[i], (i == 3 ? 1 : 0)); end
      end
      checks++; if (first_xfer_cycle != 3) begin errors++; $display("FAIL basic_first_cycle: got %0d expected 3", first_xfer_cycle); end
      checks++; if (last_xfer_cycle != 6) begin errors++; $display("FAIL basic_last_cycle: got %0d expected 6", last_xfer_cycle); end
      checks++; if (done_cycle != 7) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 7", done_cycle); end
      checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %0b expected 0", busy_at_done); end
      checks++; if (busy_cnt != 6) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 6", busy_cnt); end
      checks++; if (q_addr.size() != 4 || q_addr[0] != base) begin errors++; $display("FAIL basic_issue: got %0d issues expected 4 from %0d", q_addr.size(), base); end
   endtask

   task automatic test_backpressure();
      run(0, 4, 30, -1, 0, -1, 400);
      checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: got timeout expected done"); end
      checks++; if (q_data.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 4; i++) begin
         checks++; if (q_data[i] != i) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, q_data[i], i); end
      end
      checks++; if (viol != 0) begin errors++; $display("FAIL bp_occupancy_stability: got %0d violations expected 0", viol); end
      checks++; if (last_cnt != 1) begin errors++; $display("FAIL bp_last_count: got %0d expected 1", last_cnt); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_wrap();
      int exp_addr [4];
      exp_addr[0] = 2046; exp_addr[1] = 2047; exp_addr[2] = 0; exp_addr[3] = 1;
      run(2046, 4, 100, -1, 0, -1, 50);
      checks++; if (q_addr.size() != 4 || q_data.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d/%0d expected 4/4", q_addr.size(), q_data.size()); end
      for (int i = 0; i < 4 && i < q_addr.size() && i < q_data.size(); i++) begin
         checks++; if (q_addr[i] != exp_addr[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, q_addr[i], exp_addr[i]); end
         checks++; if (q_data[i] != exp_addr[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %0d expected %0d", i, q_data[i], exp_addr[i]); end
      end
   endtask

   task automatic test_zero_length();
      run(7, 0, 100, -1, 0, -1, 10);
      checks++; if (done_cycle != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cycle); end
      checks++; if (q_addr.size() != 0) begin errors++; $display("FAIL zero_mem_re: got %0d issues expected 0", q_addr.size()); end
      checks++; if (valid_cnt != 0) begin errors++; $display("FAIL zero_valid: got %0d cycles expected 0", valid_cnt); end
      checks++; if (busy_cnt != 0) begin errors++; $display("FAIL zero_busy: got %0d cycles expected 0", busy_cnt); end
   endtask

   task automatic test_full_depth();
      int bad;
      run(5, 2048, 100, -1, 0, -1, 2100);
      bad = 0;
      checks++; if (q_data.size() != 2048) begin errors++; $display("FAIL full_count: got %0d expected 2048", q_data.size()); end
      for (int i = 0; i < q_data.size(); i++) if (q_data[i] != (5 + i) % 2048) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL full_data: got %0d bad words expected 0", bad); end
      checks++; if (q_data.size() > 0 && q_data[q_data.size()-1] != 4) begin errors++; $display("FAIL full_final_word: got %0d expected 4", q_data[q_data.size()-1]); end
      checks++; if (last_cnt != 1 || (q_last.size() > 0 && q_last[q_last.size()-1] != 1)) begin errors++; $display("FAIL full_last: got %0d lasts expected 1 on final word", last_cnt); end
      checks++; if (done_cycle != 2048 + 3) begin errors++; $display("FAIL full_done_cycle: got %0d expected 2051", done_cycle); end
   endtask

   task automatic test_abort();
      run(0, 10, 100, 3, 0, -1, 60);
      checks++; if (abort_cycle != 6) begin errors++; $display("FAIL abort_cycle: got %0d expected 6", abort_cycle); end
      checks++; if (q_data.size() != 4) begin errors++; $display("FAIL abort_words: got %0d expected 4", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 4; i++) begin
         checks++; if (q_data[i] != i) begin errors++; $display("FAIL abort_data[%0d]: got %0d expected %0d", i, q_data[i], i); end
      end
      checks++; if (valid_after_abort !== 1'b0) begin errors++; $display("FAIL abort_valid_next: got %0b expected 0", valid_after_abort); end
      checks++; if (busy_after_abort !== 1'b0) begin errors++; $display("FAIL abort_busy_next: got %0b expected 0", busy_after_abort); end
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt); end
      test_basic(100);
   endtask

   task automatic test_start_ignored();
      run(20, 3, 100, -1, 4, 2, 60);
      checks++; if (q_data.size() != 3) begin errors++; $display("FAIL ign_count: got %0d expected 3", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 3; i++) begin
         checks++; if (q_data[i] != 20 + i) begin errors++; $display("FAIL ign_data[%0d]: got %0d expected %0d", i, q_data[i], 20 + i); end
      end
      checks++; if (q_addr.size() != 3) begin errors++; $display("FAIL ign_issues: got %0d expected 3", q_addr.size()); end
      checks++; if (viol != 0) begin errors++; $display("FAIL ign_stability: got %0d violations expected 0", viol); end
      checks++; if (done_cycle < 0) begin errors++; $display("FAIL ign_done: got none expected pulse"); end
   endtask

   task automatic test_reset_mid_run();
      @(posedge clock); #1;
      start = 1'b1; base_addr = AW'(0); length = (AW+1)'(10); out_ready = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clock); #1; start = 1'b0;
      end
      @(negedge clock);
      checks++; if (out_valid !== 1'b1 || out_data !== 16'd0) begin errors++; $display("FAIL rst_pre_full: got valid %0b data %0d expected 1/0", out_valid, out_data); end
      @(posedge clock); #1; reset_n = 1'b0;
      @(posedge clock); #1; reset_n = 1'b1;
      @(negedge clock);
      checks++; if ({busy, done, mem_re, out_valid, out_last} !== 5'b0) begin errors++; $display("FAIL rst_mid_flags: got %05b expected 00000", {busy, done, mem_re, out_valid, out_last}); end
      checks++; if (mem_addr !== '0 || out_data !== '0) begin errors++; $display("FAIL rst_mid_buses: got addr %0d data %0d expected 0/0", mem_addr, out_data); end
      test_basic(0);
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) mem_model[i] = DW'(i);
      reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      test_reset();
      test_basic(0);
      test_backpressure();
      test_wrap();
      test_zero_length();
      test_full_depth();
      test_abort();
      test_start_ignored();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
